// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the write-back slice: instruction codes,
// special register indices, and the data-path widths.
package y86_pkg;

    localparam int DATA_W = 64;
    localparam int NREGS  = 15;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    // Destination pair produced by the write-back decode.
    typedef struct packed {
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } wb_dst_t;

endpackage

// File: rtl/write_back_if.sv
// Instruction/result bundle presented to the write-back stage.
// Optional macro WB_CMOV_COND_EN adds the execute-stage condition bit cnd.
interface write_back_if
    import y86_pkg::*;
    ();

    logic [3:0]        icode;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
`ifdef WB_CMOV_COND_EN
    logic              cnd;
`endif

`ifdef WB_CMOV_COND_EN
    modport master (output icode, rA, rB, valE, valM, cnd);
    modport slave  (input  icode, rA, rB, valE, valM, cnd);
`else
    modport master (output icode, rA, rB, valE, valM);
    modport slave  (input  icode, rA, rB, valE, valM);
`endif

endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit architectural register file with synchronous reset, two write
// ports (E and M, M wins on collision) and parallel read-out of every entry.
module y86_regfile
    import y86_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   dst_e,
    input  logic [DATA_W-1:0]            val_e,
    input  logic [3:0]                   dst_m,
    input  logic [DATA_W-1:0]            val_m,
    output logic [NREGS-1:0][DATA_W-1:0] regs
);

    logic [NREGS-1:0][DATA_W-1:0] regs_r;

    // Per-entry update; RNONE matches no entry, so index 15 is never written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end else if (dst_m == 4'(i)) begin
                regs_r[i] <= val_m;
            end else if (dst_e == 4'(i)) begin
                regs_r[i] <= val_e;
            end else begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

    assign regs = regs_r;

endmodule

// File: rtl/write_back.sv
// Y86-64 SEQ write-back stage: decodes dstE/dstM from icode and commits
// valE/valM into y86_regfile. Optional macro WB_CMOV_COND_EN gates cmovXX on cnd.
module write_back
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    write_back_if.slave       wb,
    output logic [DATA_W-1:0] register0,
    output logic [DATA_W-1:0] register1,
    output logic [DATA_W-1:0] register2,
    output logic [DATA_W-1:0] register3,
    output logic [DATA_W-1:0] register4,
    output logic [DATA_W-1:0] register5,
    output logic [DATA_W-1:0] register6,
    output logic [DATA_W-1:0] register7,
    output logic [DATA_W-1:0] register8,
    output logic [DATA_W-1:0] register9,
    output logic [DATA_W-1:0] register10,
    output logic [DATA_W-1:0] register11,
    output logic [DATA_W-1:0] register12,
    output logic [DATA_W-1:0] register13,
    output logic [DATA_W-1:0] register14
);

    wb_dst_t                      dst_s;
    logic [NREGS-1:0][DATA_W-1:0] regs_s;

    // Destination decode; anything not listed (halt, nop, rmmovq, jXX, C..F) writes nothing.
    always_comb begin
        dst_s.dst_e = RNONE;
        dst_s.dst_m = RNONE;
        case (wb.icode)
            IRRMOVQ: begin
`ifdef WB_CMOV_COND_EN
                if (wb.cnd) begin
                    dst_s.dst_e = wb.rB;
                end else begin
                    dst_s.dst_e = RNONE;
                end
`else
                dst_s.dst_e = wb.rB;
`endif
            end
            IIRMOVQ, IOPQ: begin
                dst_s.dst_e = wb.rB;
            end
            IMRMOVQ: begin
                dst_s.dst_m = wb.rA;
            end
            ICALL, IRET, IPUSHQ: begin
                dst_s.dst_e = RRSP;
            end
            IPOPQ: begin
                dst_s.dst_e = RRSP;
                dst_s.dst_m = wb.rA;
            end
            default: begin
                dst_s.dst_e = RNONE;
                dst_s.dst_m = RNONE;
            end
        endcase
    end

    y86_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .dst_e (dst_s.dst_e),
        .val_e (wb.valE),
        .dst_m (dst_s.dst_m),
        .val_m (wb.valM),
        .regs  (regs_s)
    );

    assign register0  = regs_s[0];
    assign register1  = regs_s[1];
    assign register2  = regs_s[2];
    assign register3  = regs_s[3];
    assign register4  = regs_s[4];
    assign register5  = regs_s[5];
    assign register6  = regs_s[6];
    assign register7  = regs_s[7];
    assign register8  = regs_s[8];
    assign register9  = regs_s[9];
    assign register10 = regs_s[10];
    assign register11 = regs_s[11];
    assign register12 = regs_s[12];
    assign register13 = regs_s[13];
    assign register14 = regs_s[14];

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed vector table, hand sequences
// for dual-write/collision/reset corners, and randomized traffic vs a model.
module tb_write_back;

`ifdef WB_CMOV_COND_EN
    localparam bit CMOV_GATED = 1'b1;
`else
    localparam bit CMOV_GATED = 1'b0;
`endif

    logic clk;
    logic rst;
    write_back_if wb_bus ();

    logic [63:0] dut_regs [15];
    logic [63:0] model [16];
    int checks;
    int errors;

    write_back dut (
        .clk(clk), .rst(rst), .wb(wb_bus),
        .register0(dut_regs[0]),   .register1(dut_regs[1]),   .register2(dut_regs[2]),
        .register3(dut_regs[3]),   .register4(dut_regs[4]),   .register5(dut_regs[5]),
        .register6(dut_regs[6]),   .register7(dut_regs[7]),   .register8(dut_regs[8]),
        .register9(dut_regs[9]),   .register10(dut_regs[10]), .register11(dut_regs[11]),
        .register12(dut_regs[12]), .register13(dut_regs[13]), .register14(dut_regs[14])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] vale;
        logic [63:0] valm;
        logic        cnd;
        int          idx;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("%s r%0d", tag, i), dut_regs[i], model[i]);
        end
    endtask

    // Reference: the architectural effect of one committed instruction.
    task automatic model_step(input logic r, input logic [3:0] ic, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [63:0] ve,
                              input logic [63:0] vm, input logic c);
        int de;
        int dm;
        if (r) begin
            for (int i = 0; i < 16; i++) model[i] = 64'd0;
        end else begin
            de = 15;
            dm = 15;
            if (ic == 4'h2) de = (CMOV_GATED && !c) ? 15 : int'(rb);
            else if (ic == 4'h3 || ic == 4'h6) de = int'(rb);
            else if (ic >= 4'h8 && ic <= 4'hB) de = 4;
            if (ic == 4'h5 || ic == 4'hB) dm = int'(ra);
            if (de != 15) model[de] = ve;
            if (dm != 15) model[dm] = vm;
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] ve,
                         input logic [63:0] vm, input logic c);
        rst = r;
        wb_bus.icode = ic;
        wb_bus.rA = ra;
        wb_bus.rB = rb;
        wb_bus.valE = ve;
        wb_bus.valM = vm;
`ifdef WB_CMOV_COND_EN
        wb_bus.cnd = c;
`endif
    endtask

    task automatic step(input logic r, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] ve,
                        input logic [63:0] vm, input logic c);
        @(negedge clk);
        drive(r, ic, ra, rb, ve, vm, c);
        @(posedge clk);
        model_step(r, ic, ra, rb, ve, vm, c);
        #1;
    endtask

    initial begin
        logic [3:0]  ric;
        logic [3:0]  rra;
        logic [3:0]  rrb;
        logic [63:0] rve;
        logic [63:0] rvm;
        logic        rr;
        logic        rc;
        checks = 0;
        errors = 0;
        drive(1'b1, 4'h3, 4'hF, 4'h5, 64'd99, 64'd0, 1'b1);

        tbl[0]  = '{4'h2, 4'hF, 4'h5, 64'd90, 64'd0,   1'b1, 5,  64'd90,  "cmov r5"};
        tbl[1]  = '{4'h3, 4'hF, 4'h6, 64'd80, 64'd0,   1'b0, 6,  64'd80,  "irmovq r6"};
        tbl[2]  = '{4'h6, 4'hF, 4'h6, 64'd60, 64'd0,   1'b0, 6,  64'd60,  "opq r6"};
        tbl[3]  = '{4'h5, 4'hC, 4'hF, 64'd0,  64'd190, 1'b0, 12, 64'd190, "mrmovq r12"};
        tbl[4]  = '{4'h4, 4'h5, 4'h6, 64'd70, 64'd180, 1'b0, 6,  64'd60,  "rmmovq none"};
        tbl[5]  = '{4'h7, 4'h5, 4'h5, 64'd70, 64'd180, 1'b0, 5,  64'd90,  "jxx none"};
        tbl[6]  = '{4'h0, 4'hC, 4'hC, 64'd70, 64'd180, 1'b0, 12, 64'd190, "halt none"};
        tbl[7]  = '{4'h1, 4'h6, 4'h6, 64'd70, 64'd180, 1'b0, 6,  64'd60,  "nop none"};
        tbl[8]  = '{4'h8, 4'hF, 4'hF, 64'd40, 64'd0,   1'b0, 4,  64'd40,  "call rsp"};
        tbl[9]  = '{4'h9, 4'hF, 4'hF, 64'd30, 64'd0,   1'b0, 4,  64'd30,  "ret rsp"};
        tbl[10] = '{4'hA, 4'hF, 4'hF, 64'd20, 64'd0,   1'b0, 4,  64'd20,  "pushq rsp"};
        tbl[11] = '{4'h3, 4'hF, 4'hF, 64'd55, 64'd0,   1'b0, 4,  64'd20,  "rnone none"};
        tbl[12] = '{4'hC, 4'h2, 4'h2, 64'd77, 64'd78,  1'b1, 2,  64'd0,   "undef C"};
        tbl[13] = '{4'hF, 4'h4, 4'h4, 64'd77, 64'd78,  1'b1, 4,  64'd20,  "undef F"};
        tbl[14] = '{4'h2, 4'hF, 4'h3, 64'd7,  64'd0,   1'b0, 3,
                    (CMOV_GATED ? 64'd0 : 64'd7), "cmov cnd0"};
        tbl[15] = '{4'h2, 4'hF, 4'h3, 64'd7,  64'd0,   1'b1, 3,  64'd7,   "cmov cnd1"};

        // Reset with a pending irmovq: the write must be suppressed.
        @(posedge clk);
        model_step(1'b1, 4'h3, 4'hF, 4'h5, 64'd99, 64'd0, 1'b1);
        #1;
        for (int i = 0; i < 15; i++) check($sformatf("reset r%0d", i), dut_regs[i], 64'd0);

        for (int k = 0; k < 16; k++) begin
            step(1'b0, tbl[k].icode, tbl[k].ra, tbl[k].rb, tbl[k].vale, tbl[k].valm, tbl[k].cnd);
            check(tbl[k].name, dut_regs[tbl[k].idx], tbl[k].exp);
            check_all(tbl[k].name);
        end

        // popq with distinct rA: both ports land on the same edge.
        step(1'b0, 4'hB, 4'hE, 4'hF, 64'd10, 64'd140, 1'b0);
        check("popq rsp", dut_regs[4], 64'd10);
        check("popq r14", dut_regs[14], 64'd140);
        check_all("popq");

        // popq %rsp: M port wins the collision.
        step(1'b0, 4'hB, 4'h4, 4'hF, 64'd10, 64'd140, 1'b0);
        check("popq collide", dut_regs[4], 64'd140);
        check_all("collide");

        // Mid-cycle input change: only the value present at the edge counts.
        @(negedge clk);
        drive(1'b0, 4'h3, 4'hF, 4'h7, 64'd123, 64'd0, 1'b1);
        #2;
        wb_bus.icode = 4'h1;
        @(posedge clk);
        model_step(1'b0, 4'h1, 4'hF, 4'h7, 64'd123, 64'd0, 1'b1);
        #1;
        check("glitch r7", dut_regs[7], 64'd0);
        check_all("glitch");

        // Reset mid-run beats a simultaneous popq.
        step(1'b1, 4'hB, 4'h9, 4'hF, 64'd11, 64'd22, 1'b0);
        check("rst prio r4", dut_regs[4], 64'd0);
        check("rst prio r9", dut_regs[9], 64'd0);
        check_all("rst prio");

        for (int n = 0; n < 400; n++) begin
            rr  = ($urandom_range(31, 0) == 0);
            ric = 4'($urandom_range(15, 0));
            rra = 4'($urandom_range(15, 0));
            rrb = 4'($urandom_range(15, 0));
            rve = {$urandom(), $urandom()};
            rvm = {$urandom(), $urandom()};
            rc  = 1'($urandom_range(1, 0));
            step(rr, ric, rra, rrb, rve, rvm, rc);
            check_all($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Write-back stage of the Y86-64 sequential (SEQ) processor; owns the 15-entry x 64-bit architectural register file.
- Decodes icode into destination registers dstE and dstM, then commits valE and/or valM on the rising clock edge.
- Exposes all 15 registers as parallel outputs for observation and for the decode stage.

Parameters:
- DATA_W, 64, width of each register and of valE/valM.
- NREGS, 15, number of architectural registers (indices 0..14; index 15 = RNONE).

Ports:
- clk  input  1  system clock; all writes on rising edge
- rst  input  1  synchronous, active-high reset
- icode  input  4  instruction code of the current instruction
- rA  input  4  register specifier A
- rB  input  4  register specifier B
- valE  input  64  ALU result
- valM  input  64  memory read result
- register0 .. register14  output  64 each  current contents of registers 0..14 (register4 = %rsp)

Behaviour:
- Storage: 15 x 64-bit flops. Outputs are driven continuously from the flops, with no extra output register.
- Reset: a rising clk edge with rst=1 clears all 15 registers to 0. Reset has priority over any write in the same cycle.
- Destination decode (combinational):
  - dstE = rB for icode 2 (cmovXX), 3 (irmovq), 6 (OPq).
  - dstE = 4 (RRSP) for icode 8 (call), 9 (ret), A (pushq), B (popq).
  - dstE = F (RNONE) otherwise.
  - dstM = rA for icode 5 (mrmovq) and B (popq); dstM = F otherwise.
- No register change for: icode 0 (halt), 1 (nop), 4 (rmmovq), 7 (jXX), and C..F (undefined).
- Write: on a rising clk edge with rst=0:
  - R[dstE] <= valE if dstE != F.
  - R[dstM] <= valM if dstM != F.
- Index 15 is never written, and no output corresponds to it.
- Collision: if dstE == dstM (e.g. popq %rsp), the valM write wins. R[4] = valM.
- Latency: a new value is visible on the registerN output one clk edge after the inputs are presented. Inputs are sampled only at the edge.
- With no edge, outputs hold. Input changes between edges have no effect.
- Undefined icodes must not cause any write.

Optional Feature:
- Macro WB_CMOV_COND_EN.
- When defined: adds port cnd (input, 1 bit, condition-code result from execute). icode 2 (cmovXX) writes valE to R[rB] only when cnd=1; otherwise dstE=F and no write. All other icodes are unaffected by cnd.
- When undefined: no cnd port; cmovXX always writes (rrmovq semantics).

Decomposition:
- Shared package y86_pkg:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - Register constants: RRSP=4, RNONE=F.
  - Word-width constant 64.
- One sub-module, y86_regfile:
  - 15x64 storage with synchronous reset.
  - Two write ports (E and M), with port M having priority on an index collision.
  - Parallel read-out of all entries.
- write_back contains the dstE/dstM decode and instantiates y86_regfile.

Test Plan:
- Reset: assert rst for 1 cycle with icode=3, rB=5, valE=99 -> all register0..14 = 0 after the edge. The write is suppressed.
- cmovXX/irmovq/OPq:
  - icode=2, rB=5, valE=90 -> register5=90.
  - Then icode=3, rB=6, valE=80 -> register6=80.
  - Then icode=6, rB=6, valE=60 -> register6=60.
- mrmovq and no-write ops:
  - icode=5, rA=12, valM=190 -> register12=190.
  - icode=4, 7, 0, and 1 with valE=70, valM=180 -> no register changes.
- Stack ops: icode=8, valE=40 -> register4=40; icode=9, valE=30 -> 30; icode=A, valE=20 -> 20.
- popq dual write:
  - icode=B, rA=14, valE=10, valM=140 -> register4=10 and register14=140 on the same edge.
  - icode=B, rA=4, valE=10, valM=140 -> register4=140 (M wins).
- RNONE and feature:
  - icode=3, rB=F, valE=55 -> no register changes.
  - With WB_CMOV_COND_EN: icode=2, rB=3, valE=7, cnd=0 -> register3 unchanged; cnd=1 -> register3=7.
